// File: rtl/fib_index_decoder.sv
// fib_index_decoder
//   Inverse of the Fibonacci generator. It accepts a value, regenerates
//   Fibonacci terms one per clock until a term passes the value, and then
//   returns the largest term not exceeding the value. The result carries the
//   term's index, the term itself, the remainder and an exact-match flag.
//   Index convention: F(0)=0, F(1)=1. The index is the largest k with
//   F(k) <= value, so value 1 decodes to index 2.
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-low reset
//   in_valid       in_value is presented
//   in_ready       block can accept a value (IDLE only)
//   in_value       value to decode
//   out_valid      result fields valid and held (DONE only)
//   out_ready      downstream accepts result
//   out_index      largest k with F(k) <= value
//   out_floor      F(out_index)
//   out_remainder  value - out_floor
//   out_is_fib     1 when out_remainder == 0
//   busy           high in SEARCH or DONE
module fib_index_decoder #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic [WIDTH-1:0] out_floor,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_is_fib,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] val;
    logic [WIDTH-1:0] a;        // F(k)
    logic [WIDTH-1:0] b;        // F(k+1), low WIDTH bits
    logic             b_ovf;    // F(k+1) does not fit in WIDTH bits
    logic [IDX_W-1:0] k;
    logic [WIDTH:0]   sum;
    logic             found;

    // An overflowed b is larger than any WIDTH-bit input, so its wrapped
    // bits are never compared against val.
    assign sum   = {1'b0, a} + {1'b0, b};
    assign found = b_ovf || (b > val);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = SEARCH;
                end
            end
            SEARCH: begin
                busy = 1'b1;
                if (found) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            val           <= '0;
            a             <= '0;
            b             <= '0;
            b_ovf         <= 1'b0;
            k             <= '0;
            out_index     <= '0;
            out_floor     <= '0;
            out_remainder <= '0;
            out_is_fib    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        val   <= in_value;
                        a     <= '0;
                        b     <= {{(WIDTH-1){1'b0}}, 1'b1};
                        b_ovf <= 1'b0;
                        k     <= '0;
                    end
                end
                SEARCH: begin
                    if (found) begin
                        out_floor     <= a;
                        out_index     <= k;
                        out_remainder <= val - a;
                        out_is_fib    <= (val == a);
                    end else begin
                        a     <= b;
                        b     <= sum[WIDTH-1:0];
                        b_ovf <= sum[WIDTH];
                        k     <= k + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_index_decoder.sv
// tb_fib_index_decoder
//   Scoreboard bench for fib_index_decoder. The stimulus pushes the expected
//   result for each value it sends. A monitor pops and compares on every
//   output handshake.
module tb_fib_index_decoder;

    localparam int WIDTH = 32;
    localparam int IDX_W = 6;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_value;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_index;
    logic [WIDTH-1:0] out_floor;
    logic [WIDTH-1:0] out_remainder;
    logic             out_is_fib;
    logic             busy;

    typedef struct {
        int          idx;
        logic [31:0] fl;
        logic [31:0] rem;
        logic        isf;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    fib_index_decoder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_value     (in_value),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_index    (out_index),
        .out_floor    (out_floor),
        .out_remainder(out_remainder),
        .out_is_fib   (out_is_fib),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every consumed result must match the head of the scoreboard.
    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=index %0d required=no result", out_index);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("res_index", longint'(out_index), longint'(e.idx));
                check("res_floor", longint'(out_floor), longint'(e.fl));
                check("res_remainder", longint'(out_remainder), longint'(e.rem));
                check("res_is_fib", longint'(out_is_fib), longint'(e.isf));
                check("res_in_ready_low", longint'(in_ready), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Waits for in_ready (bounded), presents the value for one accepting edge.
    task automatic send(input logic [31:0] v, input bit expect_result,
                        input int idx, input logic [31:0] fl);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=in_ready 0 required=in_ready 1");
        end else begin
            if (expect_result) begin
                exp_t e;
                e.idx = idx;
                e.fl  = fl;
                e.rem = v - fl;
                e.isf = (v == fl);
                exp_q.push_back(e);
            end
            in_valid = 1'b1;
            in_value = v;
            tick();
            in_valid = 1'b0;
            in_value = '0;
        end
    endtask

    // Counts edges with the accepting edge as edge 1, up to the first out_valid.
    task automatic latency(input string name, input int req);
        int n;
        n = 1;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check(name, n, req);
    endtask

    initial begin
        longint fib[0:48];
        logic [IDX_W-1:0] h_idx;
        logic [WIDTH-1:0] h_fl;
        int guard;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_value  = '0;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_index", longint'(out_index), 0);
        check("rst_floor", longint'(out_floor), 0);
        check("rst_remainder", longint'(out_remainder), 0);
        check("rst_is_fib", longint'(out_is_fib), 0);

        // Reset mid-search: value 1000 must never produce a result.
        send(32'd1000, 1'b0, 0, 32'd0);
        tick();
        tick();
        check("mid_busy", longint'(busy), 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_in_ready", longint'(in_ready), 1);
        check("abort_busy", longint'(busy), 0);
        check("abort_out_valid", longint'(out_valid), 0);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) begin
                check("abort_no_result", longint'(out_valid), 0);
            end
        end

        // Directed values with latency checks (idx+2 edges counting accept).
        send(32'd0, 1'b1, 0, 32'd0);
        latency("lat_0", 2);
        send(32'd1, 1'b1, 2, 32'd1);
        latency("lat_1", 4);
        send(32'd100, 1'b1, 11, 32'd89);
        latency("lat_100", 13);
        send(32'd144, 1'b1, 12, 32'd144);
        latency("lat_144", 14);
        send(32'hFFFF_FFFF, 1'b1, 47, 32'd2971215073);
        latency("lat_max", 49);
        send(32'd2971215073, 1'b1, 47, 32'd2971215073);
        latency("lat_f47", 49);

        // Backpressure on value 21.
        guard = 0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        out_ready = 1'b0;
        send(32'd21, 1'b1, 8, 32'd21);
        latency("lat_21", 10);
        h_idx = out_index;
        h_fl  = out_floor;
        check("bp_index", longint'(h_idx), 8);
        check("bp_floor", longint'(h_fl), 21);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_index != h_idx || out_floor != h_fl || !out_valid || in_ready) begin
                check("bp_hold_index", longint'(out_index), longint'(h_idx));
                check("bp_hold_floor", longint'(out_floor), longint'(h_fl));
                check("bp_hold_valid", longint'(out_valid), 1);
                check("bp_hold_in_ready", longint'(in_ready), 0);
            end
        end
        check("bp_held_valid", longint'(out_valid), 1);
        check("bp_held_in_ready", longint'(in_ready), 0);
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", longint'(out_valid), 0);
        check("bp_release_in_ready", longint'(in_ready), 1);

        // Stream F(2)..F(47) back to back.
        fib[0] = 0;
        fib[1] = 1;
        for (int i = 2; i <= 48; i++) begin
            fib[i] = fib[i-1] + fib[i-2];
        end
        for (int i = 2; i <= 47; i++) begin
            send(fib[i][31:0], 1'b1, i, fib[i][31:0]);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            tick();
            guard++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fib_index_decoder.md
Name: fib_index_decoder

Overview:
Inverse of the Fibonacci sequence generator. It accepts a WIDTH-bit value over a valid/ready input handshake. It then iteratively regenerates Fibonacci terms, one per clock, until it passes the value. It returns the largest Fibonacci term not exceeding the value, that term's index, the remainder, and an exact-match flag over a valid/ready output handshake. It sits on the consumer side of the generator's data path, where it checks and classifies streamed terms.

Parameters:
WIDTH, 32, bit width of input value, floor term and remainder
IDX_W, 6, bit width of the index output (must hold the largest index whose term fits in WIDTH bits: 47 for WIDTH=32)

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
in_valid  input  1  in_value is presented
in_ready  output  1  block can accept a value
in_value  input  WIDTH  value to decode
out_valid  output  1  result fields valid and held
out_ready  input  1  downstream accepts result
out_index  output  IDX_W  largest k with F(k) <= value
out_floor  output  WIDTH  F(out_index)
out_remainder  output  WIDTH  value - out_floor
out_is_fib  output  1  1 when out_remainder == 0
busy  output  1  high in SEARCH or DONE state

Behaviour:
- Index convention: F(0)=0, F(1)=1, F(k)=F(k-1)+F(k-2). The index is always the largest k with F(k) <= value. Value 1 therefore decodes to index 2, not 1.
- Reset (reset==0 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0, except in_ready, which goes to 1.
  - Reset aborts any search or held result. Nothing is emitted afterwards.
- FSM states: IDLE, SEARCH, DONE.
- IDLE:
  - in_ready=1, out_valid=0, busy=0.
  - When in_valid && in_ready at a clock edge:
    - latch in_value into val;
    - set a=0 (F(k)), b=1 (F(k+1)), k=0;
    - go to SEARCH.
- SEARCH:
  - in_ready=0, busy=1.
  - At each edge, form sum = a + b at WIDTH+1 bits.
  - If b > val, or b is marked overflowed, then:
    - out_floor <= a;
    - out_index <= k;
    - out_remainder <= val - a;
    - out_is_fib <= (val == a);
    - out_valid <= 1;
    - go to DONE.
  - Otherwise:
    - a <= b;
    - b <= sum[WIDTH-1:0];
    - set the b-overflow flag <= sum[WIDTH];
    - k <= k+1.
  - Overflow rule: a b whose true value exceeds 2^WIDTH-1 is treated as greater than any input. The search always terminates with k <= 47 for WIDTH=32, and no wrapped term is ever compared.
- Latency: exactly idx+1 SEARCH edges. out_valid is first high in the cycle that starts idx+2 edges after the accepting edge.
- DONE:
  - out_valid=1, in_ready=0, busy=1.
  - All out_* fields stay stable until out_valid && out_ready at an edge.
  - On that edge: out_valid <= 0, go to IDLE.
  - Result fields may hold their last value after the handshake.
  - A new input is not accepted in the same edge as output consumption. There is at least one IDLE cycle between results.
- in_value and in_valid are ignored outside IDLE. Upstream must hold them until in_ready.
- out_ready is ignored outside DONE.
- Reset has priority over every handshake at the same edge.

Test Plan:
- Reset low for 2 cycles, then release → in_ready=1, out_valid=0, busy=0, all result fields 0. Then reset low mid-SEARCH (value 1000) → IDLE next cycle, no out_valid ever for that value.
- Value 0 → out_index=0, out_floor=0, out_remainder=0, out_is_fib=1, after 1 SEARCH edge. Value 1 → index 2, floor 1, rem 0, is_fib=1.
- Value 100 → index 11, floor 89, rem 11, is_fib=0. Value 144 → index 12, floor 144, rem 0, is_fib=1. out_valid appears exactly 14 edges after the accept edge.
- Value 0xFFFFFFFF → index 47, floor 2971215073, rem 1323752222, is_fib=0, with no wrap. Value 2971215073 → index 47, rem 0, is_fib=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid with value 21 → fields stay constant (index 8, floor 21), in_ready=0 throughout. Raise out_ready → out_valid drops next edge and in_ready=1 the following cycle.
- Stream the generator's outputs 1,2,3,5,...,2971215073 back-to-back → every result has is_fib=1 and rem=0, with indices 2,3,4,...,47 in order.
